// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding, owner codes and defaults for mem_arbiter
//
// Purpose: common definitions imported by mem_arbiter and arb_port_mux.
// Ports:   none (package).

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_I    = 2'b01;
  localparam logic [1:0] OWNER_D    = 2'b10;

  localparam int DEFAULT_STARVE_LIMIT = 4;
  localparam int DEFAULT_TIMEOUT      = 255;

  function automatic logic [1:0] owner_of(input arb_state_t s);
    case (s)
      GRANT_I: return OWNER_I;
      GRANT_D: return OWNER_D;
      default: return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_port_mux.sv
// rtl/arb_port_mux.sv - requester-to-memory field select and response demux
//
// Purpose: routes the owning requester's rw/address/write data onto the memory
//          port and returns read data / ready only to that owner.
// Ports:
//   owner                 current grant owner code (none / I / D)
//   complete              completion pulse for the owner this cycle
//   abort                 timeout completion: returned data forced to zero
//   i_rw/i_address/i_data_in, d_rw/d_address/d_data_in   requester fields
//   mem_out               read data from memory
//   mem_rw/mem_address/mem_in                            memory-side fields
//   i_data_out/i_ready, d_data_out/d_ready               requester responses

module arb_port_mux import mem_arb_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            owner,
  input  logic                  complete,
  input  logic                  abort,
  input  logic                  i_rw,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  d_rw,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_data_in,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_in,
  output logic [DATA_WIDTH-1:0] i_data_out,
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] d_data_out,
  output logic                  d_ready
);

  logic [DATA_WIDTH-1:0] ret_data;

  assign ret_data = abort ? '0 : mem_out;

  // Everything not belonging to the current owner stays at zero, so the
  // losing requester never sees stray data or a ready pulse.
  always_comb begin
    mem_rw      = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    i_data_out  = '0;
    i_ready     = 1'b0;
    d_data_out  = '0;
    d_ready     = 1'b0;
    case (owner)
      OWNER_I: begin
        mem_rw      = i_rw;
        mem_address = i_address;
        mem_in      = i_data_in;
        i_data_out  = ret_data;
        i_ready     = complete;
      end
      OWNER_D: begin
        mem_rw      = d_rw;
        mem_address = d_address;
        mem_in      = d_data_in;
        d_data_out  = ret_data;
        d_ready     = complete;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache memory-port arbiter with anti-starvation and timeout
//
// Purpose: shares one memory port between the I-cache and D-cache. D wins ties
//          until I has lost STARVE_LIMIT times in a row; grants that see no
//          mem_ready for TIMEOUT cycles are aborted and flagged.
// Ports:
//   clock, reset                       clock, synchronous active-high reset
//   i_strobe/i_rw/i_address/i_data_in  I-cache request
//   i_data_out/i_ready                 I-cache response
//   d_* (same set)                     D-cache request/response
//   mem_enable/mem_rw/mem_address/mem_in   memory request
//   mem_out/mem_ready                  memory response
//   timeout_err                        sticky abort flag
//   grant_owner                        00 none, 01 I, 10 D

module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_strobe,
  input  logic                  i_rw,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  output logic [DATA_WIDTH-1:0] i_data_out,
  output logic                  i_ready,
  input  logic                  d_strobe,
  input  logic                  d_rw,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_data_in,
  output logic [DATA_WIDTH-1:0] d_data_out,
  output logic                  d_ready,
  output logic                  mem_enable,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_in,
  input  logic [DATA_WIDTH-1:0] mem_out,
  input  logic                  mem_ready,
  output logic                  timeout_err,
  output logic [1:0]            grant_owner
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_MAX    = 8'(TIMEOUT);

  arb_state_t state, state_next;
  logic [3:0] starve_cnt, starve_next;
  logic [7:0] tmo_cnt, tmo_next;
  logic       err_next;
  logic       owner_strobe;
  logic       complete;
  logic       abort;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      starve_cnt  <= starve_next;
      tmo_cnt     <= tmo_next;
      timeout_err <= err_next;
    end
  end

  always_comb begin
    state_next   = state;
    starve_next  = starve_cnt;
    tmo_next     = tmo_cnt;
    err_next     = timeout_err;
    owner_strobe = 1'b0;
    complete     = 1'b0;
    abort        = 1'b0;
    case (state)
      IDLE: begin
        tmo_next = '0;
        if (i_strobe && d_strobe) begin
          // starve_cnt counts consecutive I losses; at the limit I takes the turn.
          if (starve_cnt >= STARVE_MAX) begin
            state_next  = GRANT_I;
            starve_next = '0;
          end else begin
            state_next = GRANT_D;
            if (starve_cnt != 4'hF) starve_next = starve_cnt + 4'd1;
          end
        end else if (d_strobe) begin
          state_next = GRANT_D;
        end else if (i_strobe) begin
          state_next  = GRANT_I;
          starve_next = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        owner_strobe = (state == GRANT_I) ? i_strobe : d_strobe;
        if (!owner_strobe) begin
          // Requester walked away: drop the grant silently.
          state_next = IDLE;
          tmo_next   = '0;
        end else if (mem_ready) begin
          complete   = 1'b1;
          state_next = RELEASE;
          tmo_next   = '0;
        end else if (tmo_cnt >= TMO_MAX) begin
          complete   = 1'b1;
          abort      = 1'b1;
          err_next   = 1'b1;
          state_next = RELEASE;
          tmo_next   = '0;
        end else begin
          tmo_next = tmo_cnt + 8'd1;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_enable  = (state == GRANT_I) || (state == GRANT_D);
  assign grant_owner = owner_of(state);

  arb_port_mux #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_port_mux (
    .owner       (grant_owner),
    .complete    (complete),
    .abort       (abort),
    .i_rw        (i_rw),
    .i_address   (i_address),
    .i_data_in   (i_data_in),
    .d_rw        (d_rw),
    .d_address   (d_address),
    .d_data_in   (d_data_in),
    .mem_out     (mem_out),
    .mem_rw      (mem_rw),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .i_data_out  (i_data_out),
    .i_ready     (i_ready),
    .d_data_out  (d_data_out),
    .d_ready     (d_ready)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_strobe, i_rw, d_strobe, d_rw;
  logic [31:0] i_address, i_data_in, d_address, d_data_in;
  logic [31:0] i_data_out, d_data_out;
  logic        i_ready, d_ready;
  logic        mem_enable, mem_rw;
  logic [31:0] mem_address, mem_in;
  logic [31:0] mem_out = '0;
  logic        mem_ready = 1'b0;
  logic        timeout_err;
  logic [1:0]  grant_owner;

  // requester drive state, index 0 = I side, 1 = D side
  logic [1:0]  stb = 2'b00, rw_v = 2'b00, busy = 2'b00;
  logic [31:0] addr_v [2] = '{default: '0};
  logic [31:0] wd_v   [2] = '{default: '0};
  int          raise_cyc [2] = '{default: 0};

  assign i_strobe  = stb[0];
  assign i_rw      = rw_v[0];
  assign i_address = addr_v[0];
  assign i_data_in = wd_v[0];
  assign d_strobe  = stb[1];
  assign d_rw      = rw_v[1];
  assign d_address = addr_v[1];
  assign d_data_in = wd_v[1];

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .i_strobe(i_strobe), .i_rw(i_rw), .i_address(i_address), .i_data_in(i_data_in),
    .i_data_out(i_data_out), .i_ready(i_ready),
    .d_strobe(d_strobe), .d_rw(d_rw), .d_address(d_address), .d_data_in(d_data_in),
    .d_data_out(d_data_out), .d_ready(d_ready),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_address(mem_address), .mem_in(mem_in),
    .mem_out(mem_out), .mem_ready(mem_ready),
    .timeout_err(timeout_err), .grant_owner(grant_owner)
  );

  always #5 clock = ~clock;

  typedef struct { logic [1:0] owner; logic rw; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { logic [1:0] owner; logic [31:0] data; } rsp_t;
  typedef struct { logic rw; logic [31:0] addr; logic [31:0] wdata; int hold; } drv_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  drv_t i_q[$];
  drv_t d_q[$];

  int checks = 0, passes = 0;
  int cyc = 0, rise_cyc = 0, last_lat = 0, gcycles = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // memory contents; addresses with top nibble F never answer
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hA5A5_5A5A);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // memory model: ready in the 3rd enabled cycle
  initial begin : mem_model
    int en;
    en = 0;
    forever begin
      @(posedge clock); #1;
      if (mem_enable) en++; else en = 0;
      if (mem_enable && mem_address[31:28] != 4'hF && en == 3) begin
        mem_ready = 1'b1;
        mem_out   = mem_rw ? mdata(mem_address) : '0;
      end else begin
        mem_ready = 1'b0;
        mem_out   = '0;
      end
    end
  end

  task automatic drive(input int s);
    drv_t t;
    int   n;
    bit   done, rdy;
    forever begin
      @(posedge clock); #1;
      if ((s == 0 && i_q.size() > 0) || (s == 1 && d_q.size() > 0)) begin
        if (s == 0) t = i_q.pop_front();
        else        t = d_q.pop_front();
        busy[s] = 1'b1; rw_v[s] = t.rw; addr_v[s] = t.addr; wd_v[s] = t.wdata;
        stb[s] = 1'b1; raise_cyc[s] = cyc;
        n = 0; done = 0;
        while (!done) begin
          @(negedge clock); n++;
          rdy = (s == 0) ? i_ready : d_ready;
          if (rdy) done = 1;
          else if (t.hold != 0 && n >= t.hold) done = 1;
          else if (n > 400) begin
            checks++;
            $display("FAIL ready_wait side %0d: no ready after %0d cycles, required within 400", s, n);
            done = 1;
          end
        end
        @(posedge clock); #1;
        stb[s] = 1'b0; busy[s] = 1'b0;
      end
    end
  endtask

  initial drive(0);
  initial drive(1);

  initial begin : monitor
    logic prev_en, prev_rdy;
    req_t er;
    rsp_t ers;
    prev_en = 0; prev_rdy = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_en = 0; prev_rdy = 0; gcycles = 0;
      end else begin
        gcycles = mem_enable ? gcycles + 1 : 0;
        if (mem_enable && !prev_en) begin
          rise_cyc = cyc;
          if (exp_req.size() == 0) begin
            checks++;
            $display("FAIL unexpected_grant: owner %0d addr 0x%0h, required no grant", grant_owner, mem_address);
          end else begin
            er = exp_req.pop_front();
            chk("grant_owner", grant_owner, er.owner);
            chk("mem_rw", mem_rw, er.rw);
            chk("mem_address", mem_address, er.addr);
            chk("mem_in", mem_in, er.wdata);
          end
        end
        if (prev_rdy) chk("release_enable", mem_enable, 0);
        if (i_ready || d_ready) begin
          last_lat = gcycles;
          if (exp_rsp.size() == 0) begin
            checks++;
            $display("FAIL unexpected_ready: i_ready %0b d_ready %0b, required none", i_ready, d_ready);
          end else begin
            ers = exp_rsp.pop_front();
            chk("ready_owner", {d_ready, i_ready}, ers.owner);
            chk("data_out", (ers.owner == OWNER_I) ? i_data_out : d_data_out, ers.data);
            chk("other_data_out", (ers.owner == OWNER_I) ? d_data_out : i_data_out, 0);
          end
        end
        prev_en  = mem_enable;
        prev_rdy = i_ready | d_ready;
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clock); n++;
    end while (n < 300 && !(exp_req.size() == 0 && exp_rsp.size() == 0 &&
                            i_q.size() == 0 && d_q.size() == 0 && busy == 2'b00));
    if (n >= 300) begin
      checks++;
      $display("FAIL %s: not idle after %0d cycles, required idle", nm, n);
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin : stim
    int n;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_grant_owner", grant_owner, OWNER_NONE);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_ready", {i_ready, d_ready}, 0);
    chk("rst_mem_address", mem_address, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);

    // single I read
    exp_req.push_back('{OWNER_I, 1'b1, 32'h40, 32'h0});
    exp_rsp.push_back('{OWNER_I, 32'hDEADBEEF});
    i_q.push_back('{1'b1, 32'h40, 32'h0, 0});
    wait_idle("t1");
    chk("t1_enable_latency", rise_cyc - raise_cyc[0], 1);
    chk("t1_ready_latency", last_lat, 3);

    // simultaneous: D write first, then I read
    exp_req.push_back('{OWNER_D, 1'b0, 32'h100, 32'h12345678});
    exp_req.push_back('{OWNER_I, 1'b1, 32'h180, 32'h0});
    exp_rsp.push_back('{OWNER_D, 32'h0});
    exp_rsp.push_back('{OWNER_I, mdata(32'h180)});
    d_q.push_back('{1'b0, 32'h100, 32'h12345678, 0});
    i_q.push_back('{1'b1, 32'h180, 32'h0, 0});
    wait_idle("t2");
    chk("t2_starve_cnt", dut.starve_cnt, 0);

    // starvation: four D wins, then I, then the last D
    for (int k = 0; k < 5; k++) begin
      d_q.push_back('{1'b0, 32'h200 + 32'(k * 16), 32'h1111_0000 + 32'(k), 0});
      if (k == 4) begin
        exp_req.push_back('{OWNER_I, 1'b1, 32'h280, 32'h0});
        exp_rsp.push_back('{OWNER_I, mdata(32'h280)});
      end
      exp_req.push_back('{OWNER_D, 1'b0, 32'h200 + 32'(k * 16), 32'h1111_0000 + 32'(k)});
      exp_rsp.push_back('{OWNER_D, 32'h0});
    end
    i_q.push_back('{1'b1, 32'h280, 32'h0, 0});
    wait_idle("t3");
    chk("t3_starve_cnt", dut.starve_cnt, 0);

    // timeout on a D read, then an I read still served
    chk("t4_err_before", timeout_err, 0);
    exp_req.push_back('{OWNER_D, 1'b1, 32'hF000_0010, 32'h0});
    exp_rsp.push_back('{OWNER_D, 32'h0});
    d_q.push_back('{1'b1, 32'hF000_0010, 32'h0, 0});
    wait_idle("t4a");
    chk("t4_abort_latency", last_lat, 9);
    chk("t4_err_set", timeout_err, 1);
    exp_req.push_back('{OWNER_I, 1'b1, 32'h44, 32'h0});
    exp_rsp.push_back('{OWNER_I, mdata(32'h44)});
    i_q.push_back('{1'b1, 32'h44, 32'h0, 0});
    wait_idle("t4b");
    chk("t4_err_sticky", timeout_err, 1);
    chk("t4_tmo_cnt", dut.tmo_cnt, 0);

    // reset during GRANT_D
    exp_req.push_back('{OWNER_D, 1'b1, 32'hF000_0020, 32'h0});
    d_q.push_back('{1'b1, 32'hF000_0020, 32'h0, 6});
    n = 0;
    while (!mem_enable && n < 20) begin @(negedge clock); n++; end
    chk("t5_grant_seen", grant_owner, OWNER_D);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("t5_mem_enable", mem_enable, 0);
    chk("t5_d_ready", d_ready, 0);
    chk("t5_state", dut.state, IDLE);
    chk("t5_tmo_cnt", dut.tmo_cnt, 0);
    chk("t5_starve_cnt", dut.starve_cnt, 0);
    chk("t5_err_cleared", timeout_err, 0);
    repeat (8) @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    wait_idle("t5");

    // D withdraws mid-grant; pending I goes next
    exp_req.push_back('{OWNER_D, 1'b1, 32'hF000_0200, 32'h0});
    exp_req.push_back('{OWNER_I, 1'b1, 32'h300, 32'h0});
    exp_rsp.push_back('{OWNER_I, mdata(32'h300)});
    d_q.push_back('{1'b1, 32'hF000_0200, 32'h0, 2});
    @(negedge clock);
    i_q.push_back('{1'b1, 32'h300, 32'h0, 0});
    wait_idle("t6");
    chk("t6_err_clear", timeout_err, 0);

    chk("queues_drained", exp_req.size() + exp_rsp.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run exceeded 20000 cycles, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one system memory port between the instruction-cache and data-cache miss/fill/write-through system interfaces (Strobe/RW/Address/Data/Ready).
- Sits between the cache pair and a single unified memory.
- Grants one requester per transaction.
- Data side has fixed priority; an anti-starvation counter guarantees instruction-side progress.
- Flags memory transactions that never complete.

Parameters:
- ADDR_WIDTH, 32, requester/memory address width.
- DATA_WIDTH, 32, data width.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which the I side wins (1..15).
- TIMEOUT, 255, max cycles in a grant state without mem_ready before abort (1..255).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- i_strobe  in  1  I-cache request; held high until i_ready.
- i_rw  in  1  1=read, 0=write.
- i_address  in  ADDR_WIDTH  I request address.
- i_data_in  in  DATA_WIDTH  I write data.
- i_data_out  out  DATA_WIDTH  read data to I-cache.
- i_ready  out  1  one-cycle completion pulse to I-cache.
- d_strobe, d_rw, d_address, d_data_in, d_data_out, d_ready: same as the I-cache signals, for the D-cache.
- mem_enable  out  1  memory strobe.
- mem_rw  out  1  1=read, 0=write.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_in  out  DATA_WIDTH  write data to memory.
- mem_out  in  DATA_WIDTH  read data from memory.
- mem_ready  in  1  one-cycle completion pulse from memory.
- timeout_err  out  1  sticky abort flag.
- grant_owner  out  2  00=none, 01=I, 10=D (debug).

Behaviour:
- Reset:
  - state=IDLE, starve_cnt=0, tmo_cnt=0.
  - timeout_err=0, grant_owner=00.
  - All outputs 0.
  - Reset mid-transaction drops mem_enable on the next edge; no ready pulse is generated.
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE arbitration, registered:
  - Grant state is entered on the edge after the strobe is seen, so mem_enable rises 1 cycle after the request (minimum latency).
  - Both strobes, starve_cnt<STARVE_LIMIT: GRANT_D, starve_cnt++.
  - Both strobes, starve_cnt==STARVE_LIMIT: GRANT_I, starve_cnt=0.
  - Only d_strobe: GRANT_D; starve_cnt unchanged.
  - Only i_strobe: GRANT_I, starve_cnt=0.
  - Neither: stay in IDLE.
- GRANT_x:
  - mem_enable=1.
  - mem_rw/mem_address/mem_in muxed combinationally from requester x's live inputs (requester holds them stable).
  - x_data_out=mem_out.
  - x_ready=mem_ready, combinational, same cycle.
  - On mem_ready: go to RELEASE, tmo_cnt=0.
  - Else tmo_cnt++.
  - If tmo_cnt reaches TIMEOUT: set timeout_err, pulse x_ready with x_data_out=0, go to RELEASE.
  - If x_strobe drops before ready (protocol violation): return to IDLE with no ready pulse.
- RELEASE:
  - One dead cycle; mem_enable=0 and no ready outputs.
  - Lets the requester deassert its strobe.
  - Always go to IDLE.
  - Back-to-back transactions from one requester are therefore spaced ≥3 cycles apart (grant, ready, release).
- Ownership:
  - The non-granted requester's ready and data_out are held at 0.
  - A grant is never preempted.
- timeout_err:
  - Sticky until reset.
  - Does not block further arbitration.
- grant_owner reflects the current state.
- Widths: counters saturate, never wrap; starve_cnt is 4 bits, tmo_cnt is 8 bits.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding (IDLE=2'd0, GRANT_I=2'd1, GRANT_D=2'd2, RELEASE=2'd3);
  - the grant_owner codes;
  - default STARVE_LIMIT and TIMEOUT constants.
- One sub-module, arb_port_mux: combinational select of the requester fields onto the memory port and demux of mem_out/mem_ready back to the owner.
- FSM and counters stay in mem_arbiter.

Test Plan:
- Single I read: i_strobe=1, i_address=0x40, i_rw=1; memory replies mem_ready with mem_out=0xDEADBEEF 2 cycles after enable.
  - Required: mem_enable at cycle+1, mem_address=0x40, i_ready pulse with i_data_out=0xDEADBEEF, d_ready=0, then RELEASE and mem_enable=0.
- Simultaneous I and D requests, STARVE_LIMIT=4: D is granted first.
  - Required: D write to 0x100 with data 0x12345678 appears on mem_in before the I read is issued.
- Starvation: d_strobe held continuously, i_strobe held.
  - Required: exactly 4 D grants, then a GRANT_I; starve_cnt returns to 0.
- Timeout, TIMEOUT=8: D read, mem_ready never asserted.
  - Required: after 8 grant cycles, d_ready pulses with d_data_out=0, timeout_err=1 stays set, and a following I request is still served.
- Reset asserted during GRANT_D:
  - Required: next edge gives state IDLE, mem_enable=0, no d_ready, counters 0, timeout_err cleared.
- Strobe withdrawn mid-grant: D deasserts before mem_ready.
  - Required: return to IDLE with no d_ready; a pending I request is granted next.
